// File: rtl/lcd_controller.sv
`default_nettype none
// ============================================================================
// lcd_controller: HD44780 4-bit power-up/init sequencer and nibble-port
// arbiter between the init engine and the text-sender client.   Rev 1.0
// ============================================================================
module lcd_controller #(
    parameter int POWERUP_CYCLES  = 750000,
    parameter int INIT_GAP_CYCLES = 250000,
    parameter int REFRESH_CYCLES  = 5000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       refresh_req,
    output logic       ready,
    output logic       busy,
    output logic       text_start,
    input  logic       text_done,
    input  logic [3:0] client_cmd,
    input  logic       client_cmd_send,
    input  logic       client_cmd_rs,
    input  logic       client_read_busy,
    output logic       client_cmd_done,
    output logic [3:0] cmd,
    output logic       cmd_send,
    output logic       cmd_rs,
    output logic       cmd_read_busy,
    input  logic       cmd_done
);

    localparam int c_PWR_W = (POWERUP_CYCLES  > 1) ? $clog2(POWERUP_CYCLES)  : 1;
    localparam int c_GAP_W = (INIT_GAP_CYCLES > 1) ? $clog2(INIT_GAP_CYCLES) : 1;
    localparam int c_REF_W = (REFRESH_CYCLES  > 1) ? $clog2(REFRESH_CYCLES)  : 1;

    localparam logic [c_PWR_W-1:0] c_PWR_LAST = c_PWR_W'(POWERUP_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(INIT_GAP_CYCLES - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_CYCLES - 1);

    localparam logic [3:0] c_IDX_LAST_WAKE = 4'd3;
    localparam logic [3:0] c_IDX_LAST      = 4'd11;

    typedef enum logic [2:0] {
        PWR_WAIT   = 3'd0,
        INIT_SEND  = 3'd1,
        INIT_WAIT  = 3'd2,
        INIT_GAP   = 3'd3,
        IDLE       = 3'd4,
        TEXT_START = 3'd5,
        TEXT_RUN   = 3'd6
    } state_t;

    state_t               state_q,   state_d;
    logic [3:0]           idx_q,     idx_d;
    logic [c_PWR_W-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [c_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [c_REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic                 pending_q, pending_d;
    logic                 ready_q,   ready_d;
    logic [3:0]           cmd_q,     cmd_d;
    logic                 rs_q,      rs_d;
    logic                 rb_q,      rb_d;
    logic                 send_q,    send_d;

    // Init ROM: {read_busy, nibble}; the low nibble of each pair polls busy.
    logic [4:0] rom_word;
    always_comb begin
        rom_word = 5'b0_0000;
        case (idx_q)
            4'd0:    rom_word = 5'b0_0011;
            4'd1:    rom_word = 5'b0_0011;
            4'd2:    rom_word = 5'b0_0011;
            4'd3:    rom_word = 5'b0_0010;
            4'd4:    rom_word = 5'b0_0010;
            4'd5:    rom_word = 5'b1_1000;
            4'd6:    rom_word = 5'b0_0000;
            4'd7:    rom_word = 5'b1_1100;
            4'd8:    rom_word = 5'b0_0000;
            4'd9:    rom_word = 5'b1_0001;
            4'd10:   rom_word = 5'b0_0000;
            4'd11:   rom_word = 5'b1_0110;
            default: rom_word = 5'b0_0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pwr_cnt_d = pwr_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ref_cnt_d = ref_cnt_q;
        ready_d   = ready_q;
        cmd_d     = cmd_q;
        rs_d      = rs_q;
        rb_d      = rb_q;
        send_d    = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (pwr_cnt_q == c_PWR_LAST) begin
                    pwr_cnt_d = '0;
                    state_d   = INIT_SEND;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            INIT_SEND: begin
                // Nibble fields and the send strobe are registered together,
                // so the driver sees a stable word in the strobe cycle.
                cmd_d   = rom_word[3:0];
                rb_d    = rom_word[4];
                rs_d    = 1'b0;
                send_d  = 1'b1;
                state_d = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (cmd_done) begin
                    if (idx_q <= c_IDX_LAST_WAKE) begin
                        gap_cnt_d = '0;
                        state_d   = INIT_GAP;
                    end else if (idx_q == c_IDX_LAST) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = INIT_SEND;
                    end
                end
            end
            INIT_GAP: begin
                if (gap_cnt_q == c_GAP_LAST) begin
                    gap_cnt_d = '0;
                    idx_d     = idx_q + 1'b1;
                    state_d   = INIT_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (pending_q || (ref_cnt_q == c_REF_LAST)) begin
                    state_d = TEXT_START;
                end else begin
                    ref_cnt_d = ref_cnt_q + 1'b1;
                end
            end
            TEXT_START: begin
                ref_cnt_d = '0;
                state_d   = TEXT_RUN;
            end
            TEXT_RUN: begin
                if (text_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase
    end

    // A request coinciding with TEXT_START is absorbed by the transfer
    // being launched, so the clear takes priority.
    always_comb begin
        pending_d = pending_q;
        if (state_q == TEXT_START) begin
            pending_d = 1'b0;
        end else if (refresh_req) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= PWR_WAIT;
            idx_q     <= 4'd0;
            pwr_cnt_q <= '0;
            gap_cnt_q <= '0;
            ref_cnt_q <= '0;
            pending_q <= 1'b1;
            ready_q   <= 1'b0;
            cmd_q     <= 4'd0;
            rs_q      <= 1'b0;
            rb_q      <= 1'b0;
            send_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pwr_cnt_q <= pwr_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            cmd_q     <= cmd_d;
            rs_q      <= rs_d;
            rb_q      <= rb_d;
            send_q    <= send_d;
        end
    end

    // Strobes are masked by RESET so nothing reaches the driver or the
    // text sender while reset is held, even before the first reset edge.
    always_comb begin
        ready      = ready_q;
        busy       = (state_q != IDLE);
        text_start = (state_q == TEXT_START) && !RESET;
        if (state_q == TEXT_RUN) begin
            cmd             = client_cmd;
            cmd_send        = client_cmd_send && !RESET;
            cmd_rs          = client_cmd_rs;
            cmd_read_busy   = client_read_busy;
            client_cmd_done = cmd_done;
        end else begin
            cmd             = cmd_q;
            cmd_send        = send_q && !RESET;
            cmd_rs          = rs_q;
            cmd_read_busy   = rb_q;
            client_cmd_done = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// ============================================================================
// tb_lcd_controller: directed self-checking bench with driver/client models.
// Rev 1.0
// ============================================================================
module tb_lcd_controller;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       refresh_req;
    logic       ready, busy, text_start, text_done;
    logic [3:0] client_cmd;
    logic       client_cmd_send, client_cmd_rs, client_read_busy, client_cmd_done;
    logic [3:0] cmd;
    logic       cmd_send, cmd_rs, cmd_read_busy, cmd_done;

    lcd_controller #(
        .POWERUP_CYCLES  (10),
        .INIT_GAP_CYCLES (4),
        .REFRESH_CYCLES  (50)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .refresh_req      (refresh_req),
        .ready            (ready),
        .busy             (busy),
        .text_start       (text_start),
        .text_done        (text_done),
        .client_cmd       (client_cmd),
        .client_cmd_send  (client_cmd_send),
        .client_cmd_rs    (client_cmd_rs),
        .client_read_busy (client_read_busy),
        .client_cmd_done  (client_cmd_done),
        .cmd              (cmd),
        .cmd_send         (cmd_send),
        .cmd_rs           (cmd_rs),
        .cmd_read_busy    (cmd_read_busy),
        .cmd_done         (cmd_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] nib;
        logic       rb;
        int         gap_after;   // cmd_done -> next cmd_send
    } init_vec_t;

    init_vec_t tbl [12];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int dd      = 0;
    int tdcnt   = 0;

    int         send_cyc [$];
    logic [3:0] send_nib [$];
    logic       send_rb  [$];
    logic       send_rs  [$];
    int         ts_cyc   [$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ts_at(input int i);
        return (i < ts_cyc.size()) ? ts_cyc[i] : -1;
    endfunction

    // Log the ending cycle, advance one clock, then drive the models.
    task automatic step();
        if (cmd_send) begin
            send_cyc.push_back(cyc);
            send_nib.push_back(cmd);
            send_rb.push_back(cmd_read_busy);
            send_rs.push_back(cmd_rs);
            dd = 3;
        end
        if (text_start) begin
            ts_cyc.push_back(cyc);
            tdcnt = 20;
        end
        @(posedge CLK);
        #1;
        cyc++;
        cmd_done = 1'b0;
        if (dd > 0) begin
            dd--;
            if (dd == 0) cmd_done = 1'b1;
        end
        text_done = 1'b0;
        if (tdcnt > 0) begin
            tdcnt--;
            if (tdcnt == 0) text_done = 1'b1;
        end
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        #1;
        chk("rst_async_cmd_send", cmd_send, 0);
        chk("rst_async_text_start", text_start, 0);
        step();
        step();
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_text_start", text_start, 0);
        chk("rst_cmd_send", cmd_send, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_cmd_rs", cmd_rs, 0);
        chk("rst_cmd_read_busy", cmd_read_busy, 0);
        chk("rst_client_cmd_done", client_cmd_done, 0);
        RESET     = 1'b0;
        dd        = 0;
        tdcnt     = 0;
        cmd_done  = 1'b0;
        text_done = 1'b0;
        cyc       = 0;
        send_cyc.delete();
        send_nib.delete();
        send_rb.delete();
        send_rs.delete();
        ts_cyc.delete();
        #1;
        chk("cyc0_busy", busy, 1);
        chk("cyc0_cmd_send", cmd_send, 0);
        chk("cyc0_ready", ready, 0);
    endtask

    task automatic check_init();
        int exp_s;
        while (!ready && cyc < 300) begin
            step();
            if (cyc == 14) chk("init_client_done_masked", client_cmd_done, 0);
            if (cyc == 15) begin
                client_cmd      = 4'hA;
                client_cmd_rs   = 1'b1;
                client_cmd_send = 1'b1;
                #1;
                chk("init_isolate_send", cmd_send, 0);
                chk("init_isolate_cmd", cmd, 3);
            end
            if (cyc == 16) begin
                client_cmd      = 4'h0;
                client_cmd_rs   = 1'b0;
                client_cmd_send = 1'b0;
            end
        end
        chk("init_ready", ready, 1);
        chk("ready_cycle", cyc, 86);
        chk("init_send_count", send_cyc.size(), 12);
        if (send_cyc.size() >= 12) begin
            exp_s = 11;
            for (int i = 0; i < 12; i++) begin
                if (i == 0) chk("first_send_cycle", send_cyc[0], exp_s);
                else        chk("gap_spacing", send_cyc[i] - send_cyc[i-1] - 3, tbl[i-1].gap_after);
                chk("init_nibble", send_nib[i], tbl[i].nib);
                chk("init_read_busy", send_rb[i], tbl[i].rb);
                chk("init_rs", send_rs[i], 0);
                exp_s = exp_s + 3 + tbl[i].gap_after;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'h3, 1'b0, 6};
        tbl[1]  = '{4'h3, 1'b0, 6};
        tbl[2]  = '{4'h3, 1'b0, 6};
        tbl[3]  = '{4'h2, 1'b0, 6};
        tbl[4]  = '{4'h2, 1'b0, 2};
        tbl[5]  = '{4'h8, 1'b1, 2};
        tbl[6]  = '{4'h0, 1'b0, 2};
        tbl[7]  = '{4'hC, 1'b1, 2};
        tbl[8]  = '{4'h0, 1'b0, 2};
        tbl[9]  = '{4'h1, 1'b1, 2};
        tbl[10] = '{4'h0, 1'b0, 2};
        tbl[11] = '{4'h6, 1'b1, 2};

        RESET            = 1'b1;
        refresh_req      = 1'b0;
        text_done        = 1'b0;
        cmd_done         = 1'b0;
        client_cmd       = 4'h0;
        client_cmd_send  = 1'b0;
        client_cmd_rs    = 1'b0;
        client_read_busy = 1'b0;

        apply_reset();
        check_init();

        // First transfer follows init; then pass-through in TEXT_RUN.
        run_to(88);
        chk("first_text_start", ts_at(0), 87);
        run_to(90);
        client_cmd      = 4'hA;
        client_cmd_rs   = 1'b1;
        client_cmd_send = 1'b1;
        #1;
        chk("pass_cmd", cmd, 10);
        chk("pass_rs", cmd_rs, 1);
        chk("pass_send", cmd_send, 1);
        chk("pass_read_busy", cmd_read_busy, 0);
        step();
        client_cmd      = 4'h0;
        client_cmd_rs   = 1'b0;
        client_cmd_send = 1'b0;
        #1;
        chk("pass_send_drop", cmd_send, 0);
        run_to(93);
        chk("pass_client_done", client_cmd_done, 1);
        run_to(108);
        chk("idle_after_done", busy, 0);

        // Periodic refresh, then merged requests during TEXT_RUN.
        run_to(159);
        chk("periodic_text_start", ts_at(1), 158);
        for (int k = 0; k < 3; k++) begin
            run_to(160 + 3 * k);
            refresh_req = 1'b1;
            step();
            refresh_req = 1'b0;
        end
        run_to(181);
        chk("merged_text_start", ts_at(2), 180);
        run_to(251);
        chk("periodic_after_merge", text_start, 1);
        refresh_req = 1'b1;
        step();
        refresh_req = 1'b0;
        run_to(323);
        chk("req_in_text_start_dropped", ts_at(3), 251);
        chk("periodic_after_drop", ts_at(4), 322);
        chk("text_start_count", ts_cyc.size(), 5);

        // Reset mid-text, then reset again mid-init at entry 6.
        run_to(330);
        apply_reset();
        run_to(58);
        chk("entry6_sends", send_cyc.size(), 7);
        if (send_nib.size() >= 7) chk("entry6_nibble", send_nib[6], 0);
        apply_reset();
        check_init();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_controller.md
# lcd_controller

Top-level sequencer for the HD44780 4-bit LCD path. After reset it waits out the panel power-up time and issues the fixed 4-bit initialisation nibble sequence on the nibble-driver port. It then grants that port to the text-sender client and starts a text transfer on every refresh period, or on request. It is the only master of the nibble driver; the text sender reaches the driver exclusively through this block.

## Interface
Parameters:
- POWERUP_CYCLES, 750000: cycles waited after reset before the first init nibble (15 ms at 50 MHz).
- INIT_GAP_CYCLES, 250000: idle cycles inserted after each of the four single-nibble wake-up entries.
- REFRESH_CYCLES, 5000000: period between automatic text refreshes, counted in IDLE.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- refresh_req  in  1  request an immediate text update; level or pulse.
- ready  out  1  high once init is complete.
- busy  out  1  high in every state except IDLE.
- text_start  out  1  one-cycle pulse that starts the text sender (drives its sendText).
- text_done  in  1  one-cycle pulse from the text sender when the transfer finishes.
- client_cmd  in  4  client nibble.
- client_cmd_send  in  1  client send pulse.
- client_cmd_rs  in  1  client RS.
- client_read_busy  in  1  client busy-poll flag.
- client_cmd_done  out  1  driver completion, forwarded to the client.
- cmd  out  4  nibble to the driver.
- cmd_send  out  1  one-cycle send pulse to the driver.
- cmd_rs  out  1  RS to the driver.
- cmd_read_busy  out  1  tells the driver to poll the busy flag after this nibble.
- cmd_done  in  1  driver completion pulse.

## Operation
States:
- PWR_WAIT: counts POWERUP_CYCLES, then goes to INIT_SEND.
- INIT_SEND: asserts cmd_send for one cycle with ROM entry idx, then goes to INIT_WAIT.
- INIT_WAIT: on cmd_done, goes to INIT_GAP if idx ≤ 3, to IDLE if idx = 11, otherwise to INIT_SEND with idx+1.
- INIT_GAP: counts INIT_GAP_CYCLES, then goes to INIT_SEND with idx+1.
- IDLE: goes to TEXT_START when a refresh is pending or the refresh counter reaches REFRESH_CYCLES-1.
- TEXT_START: asserts text_start for one cycle, clears the pending flag and the refresh counter, then goes to TEXT_RUN.
- TEXT_RUN: waits for text_done, then returns to IDLE.

Init ROM (12 entries, idx 0..11, all rs=0):
- Entries 0..3: nibbles 3, 3, 3, 2, each with read_busy=0.
- Entries 4..11: nibble pairs 2/8, 0/C, 0/1, 0/6.
- In each pair the high nibble has read_busy=0 and the low nibble has read_busy=1.

Port arbitration:
- In TEXT_RUN, cmd, cmd_send, cmd_rs and cmd_read_busy are a combinational pass-through of the client_* inputs, and client_cmd_done = cmd_done.
- In every other state, the driver port is owned by the init engine (or idle), client_cmd_done = 0, and client_cmd_send is ignored (dropped).

Pending refresh:
- One-bit flag, set to 1 by reset so the first text transfer follows init immediately.
- Set by refresh_req in any state except TEXT_START; multiple requests merge into one.
- refresh_req and TEXT_START in the same cycle: the flag ends up clear.
- A request raised during TEXT_RUN is serviced by a second transfer directly after text_done.

Other rules:
- ready goes high on entry to IDLE after entry 11 and stays high until RESET.
- Ignored inputs: text_done outside TEXT_RUN, and cmd_done outside INIT_WAIT/TEXT_RUN.
- Counters are sized with $clog2 of their parameter and only ever count up to parameter-1.

## Timing
- During RESET, and in the first cycle after its release:
  - state = PWR_WAIT, idx = 0, pending = 1;
  - ready = 0, busy = 1, text_start = 0;
  - cmd_send = 0, cmd = 0, cmd_rs = 0, cmd_read_busy = 0, client_cmd_done = 0.
- First cmd_send occurs exactly POWERUP_CYCLES+1 cycles after RESET deasserts.
- Init-driven cmd, cmd_rs and cmd_read_busy are registered. They are valid in the cmd_send cycle and held until the next INIT_SEND.
- cmd_done to the next cmd_send:
  - 2 cycles after paired entries (INIT_WAIT → INIT_SEND);
  - INIT_GAP_CYCLES+2 cycles after entries 0..3.
- cmd_done for entry 11 at cycle t: ready = 1 at t+1, text_start at t+2.
- text_done at cycle t: busy = 0 at t+1; if pending, text_start at t+2.
- Pass-through adds zero latency in TEXT_RUN.
- RESET asserted mid-init or mid-text:
  - returns to PWR_WAIT and reruns the full init;
  - cmd_send never pulses during or in the first cycle after RESET;
  - the text sender must be reset on the same RESET.

## Test plan
Bench settings: POWERUP_CYCLES=10, INIT_GAP_CYCLES=4, REFRESH_CYCLES=50; driver model pulses cmd_done 3 cycles after cmd_send.

- Init sequence: release reset → first cmd_send at cycle 11, then 12 cmd_send pulses carrying nibbles 3,3,3,2,2,8,0,C,0,1,0,6 with read_busy 0,0,0,0,0,1,0,1,0,1,0,1 and rs always 0 → ready = 1 one cycle after the 12th cmd_done.
- Gap spacing: measure cmd_done→cmd_send → 6 cycles after entries 0..3, 2 cycles for later entries.
- Auto start and periodic refresh: ready rises → text_start 1 cycle later; client model returns text_done after 20 cycles → next text_start after 50 IDLE cycles.
- Pass-through and isolation: client_cmd=A, rs=1, send during TEXT_RUN → cmd=A, cmd_rs=1, cmd_send in the same cycle, and cmd_done is echoed on client_cmd_done. The same client pulse during init produces no cmd_send.
- Merged requests: three refresh_req pulses during TEXT_RUN → exactly one extra text_start, 2 cycles after text_done.
- Mid-operation reset: RESET during init entry 6 → all outputs 0, ready = 0, and the full 12-entry sequence restarts with entry 0 at cycle 11.
